// File: rtl/div_pkg.sv
// Shared constants for the sequential divider: FSM encoding and counter sizing.
package div_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Bits needed to count 0..value-1; only meaningful for value >= 2.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((32'd1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/addsub_unit.sv
// Ripple-carry adder/subtractor: m=0 gives a+b, m=1 gives a-b (b inverted, carry-in 1).
module addsub_unit #(
  parameter int unsigned WIDTH = 5
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             m,
  output logic [WIDTH-1:0] sum
);

  logic [WIDTH-1:0] b_eff;
  logic             carry;

  assign b_eff = b ^ {WIDTH{m}};

  always_comb begin
    sum   = '0;
    carry = m;
    for (int i = 0; i < WIDTH; i++) begin
      sum[i] = a[i] ^ b_eff[i] ^ carry;
      carry  = (a[i] & b_eff[i]) | (carry & (a[i] ^ b_eff[i]));
    end
  end

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle unsigned restoring divider, one trial subtraction per clock,
// with a start/busy/done handshake and divide-by-zero flag.
module seq_divider
  import div_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_zero
);

  localparam int unsigned CntW = clog2(WIDTH);

  logic [1:0]       state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [WIDTH:0]   rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH-1:0] quotient_q, quotient_d;
  logic [WIDTH-1:0] remainder_q, remainder_d;
  logic             div_zero_q, div_zero_d;

  logic [WIDTH:0]   rem_shift;
  logic [WIDTH:0]   trial;
  logic [WIDTH:0]   rem_next;
  logic [WIDTH-1:0] quo_next;
  logic             trial_ok;

  // Shift the next dividend bit into the partial remainder.
  assign rem_shift = (rem_q << 1) | {{WIDTH{1'b0}}, quo_q[WIDTH-1]};

  addsub_unit #(
    .WIDTH (WIDTH + 1)
  ) u_trial_sub (
    .a   (rem_shift),
    .b   ({1'b0, dvs_q}),
    .m   (1'b1),
    .sum (trial)
  );

  assign trial_ok = ~trial[WIDTH];
  assign rem_next = trial_ok ? trial : rem_shift;
  assign quo_next = {quo_q[WIDTH-2:0], trial_ok};

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rem_d       = rem_q;
    quo_d       = quo_q;
    dvs_d       = dvs_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    div_zero_d  = div_zero_q;

    case (state_q)
      ST_RUN: begin
        rem_d = rem_next;
        quo_d = quo_next;
        cnt_d = cnt_q + CntW'(1);
        if (cnt_q == CntW'(WIDTH - 1)) begin
          state_d     = ST_DONE;
          quotient_d  = quo_next;
          remainder_d = rem_next[WIDTH-1:0];
        end
      end
      default: begin
        // IDLE and DONE both accept a new request.
        state_d = ST_IDLE;
        if (start) begin
          dvs_d      = divisor;
          quo_d      = dividend;
          rem_d      = '0;
          cnt_d      = '0;
          div_zero_d = (divisor == '0);
          if (divisor == '0) begin
            state_d     = ST_DONE;
            quotient_d  = '1;
            remainder_d = dividend;
          end else begin
            state_d = ST_RUN;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      dvs_q       <= '0;
      quotient_q  <= '0;
      remainder_q <= '0;
      div_zero_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rem_q       <= rem_d;
      quo_q       <= quo_d;
      dvs_q       <= dvs_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      div_zero_q  <= div_zero_d;
    end
  end

  assign busy      = (state_q == ST_RUN);
  assign done      = (state_q == ST_DONE);
  assign quotient  = quotient_q;
  assign remainder = remainder_q;
  assign div_zero  = div_zero_q;

endmodule
